// File: rtl/id_stage.sv
// Instruction decode stage: 32x32 register file, RV32I field/immediate decode,
// load-use hazard detection and the ID->EX pipeline register.
// Optional feature macro: ID_WB_BYPASS_EN (writeback data bypassed into the
// same-cycle register read when defined).
module id_stage #(
  parameter int unsigned RF_DEPTH = 32,
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst_id,
  input  logic [29:0] i_pc_id,
  input  logic        i_stall,
  input  logic        i_rst_pipe,
  input  logic        i_wb_wen,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_wdata,
  output logic        o_stall_ld,
  output logic        o_valid_ex,
  output logic [29:0] o_pc_ex,
  output logic [31:0] o_rs1_data_ex,
  output logic [31:0] o_rs2_data_ex,
  output logic [4:0]  o_rs1_ex,
  output logic [4:0]  o_rs2_ex,
  output logic [4:0]  o_rd_ex,
  output logic [31:0] o_imm_ex,
  output logic [6:0]  o_opcode_ex,
  output logic [2:0]  o_funct3_ex,
  output logic        o_funct7b5_ex,
  output logic        o_wen_ex,
  output logic        o_ld_ex,
  output logic        o_st_ex,
  output logic        o_illegal_ex
);

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  // Register file; entry 0 is never written and never read.
  logic [31:0] r_rf [RF_DEPTH];

  // ID->EX pipeline register.
  logic        r_valid_ex;
  logic [29:0] r_pc_ex;
  logic [31:0] r_rs1_data_ex;
  logic [31:0] r_rs2_data_ex;
  logic [4:0]  r_rs1_ex;
  logic [4:0]  r_rs2_ex;
  logic [4:0]  r_rd_ex;
  logic [31:0] r_imm_ex;
  logic [6:0]  r_opcode_ex;
  logic [2:0]  r_funct3_ex;
  logic        r_funct7b5_ex;
  logic        r_wen_ex;
  logic        r_ld_ex;
  logic        r_st_ex;
  logic        r_illegal_ex;

  // Decoded fields of the instruction currently in ID.
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic [31:0] w_imm;
  logic        w_wen;
  logic        w_ld;
  logic        w_st;
  logic        w_illegal;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic [31:0] w_rs1_rf;
  logic [31:0] w_rs2_rf;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_stall_ld;

  assign w_opcode   = i_inst_id[6:0];
  assign w_rd       = i_inst_id[11:7];
  assign w_funct3   = i_inst_id[14:12];
  assign w_rs1      = i_inst_id[19:15];
  assign w_rs2      = i_inst_id[24:20];
  assign w_funct7b5 = i_inst_id[30];

  // Opcode decode: immediate format, control flags and operand usage.
  always_comb begin
    w_imm      = '0;
    w_wen      = 1'b0;
    w_ld       = 1'b0;
    w_st       = 1'b0;
    w_illegal  = 1'b0;
    w_rs1_used = 1'b1;
    w_rs2_used = 1'b0;
    unique case (w_opcode)
      OpcLoad: begin
        w_imm = {{20{i_inst_id[31]}}, i_inst_id[31:20]};
        w_wen = 1'b1;
        w_ld  = 1'b1;
      end
      OpcOpImm, OpcJalr: begin
        w_imm = {{20{i_inst_id[31]}}, i_inst_id[31:20]};
        w_wen = 1'b1;
      end
      OpcStore: begin
        w_imm      = {{20{i_inst_id[31]}}, i_inst_id[31:25], i_inst_id[11:7]};
        w_st       = 1'b1;
        w_rs2_used = 1'b1;
      end
      OpcBranch: begin
        w_imm      = {{19{i_inst_id[31]}}, i_inst_id[31], i_inst_id[7],
                      i_inst_id[30:25], i_inst_id[11:8], 1'b0};
        w_rs2_used = 1'b1;
      end
      OpcLui, OpcAuipc: begin
        w_imm      = {i_inst_id[31:12], 12'b0};
        w_wen      = 1'b1;
        w_rs1_used = 1'b0;
      end
      OpcJal: begin
        w_imm      = {{11{i_inst_id[31]}}, i_inst_id[31], i_inst_id[19:12],
                      i_inst_id[20], i_inst_id[30:21], 1'b0};
        w_wen      = 1'b1;
        w_rs1_used = 1'b0;
      end
      OpcOp: begin
        w_wen      = 1'b1;
        w_rs2_used = 1'b1;
      end
      OpcSystem: begin
        w_wen = 1'b1;
      end
      OpcMiscMem: begin
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // x0 destinations never produce a write
    if (w_rd == 5'd0) begin
      w_wen = 1'b0;
    end
  end

  // Register file read with x0 forced to zero, plus optional WB bypass.
  always_comb begin
    w_rs1_rf = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
    w_rs2_rf = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
`ifdef ID_WB_BYPASS_EN
    w_rs1_data = (i_wb_wen && (i_wb_rd != 5'd0) && (i_wb_rd == w_rs1)) ? i_wb_wdata : w_rs1_rf;
    w_rs2_data = (i_wb_wen && (i_wb_rd != 5'd0) && (i_wb_rd == w_rs2)) ? i_wb_wdata : w_rs2_rf;
`else
    // Old array value; the EX forwarding network covers the WB->ID case.
    w_rs1_data = w_rs1_rf;
    w_rs2_data = w_rs2_rf;
`endif
  end

  // Load-use hazard against the load in EX; suppressed while flushing.
  always_comb begin
    w_stall_ld = r_valid_ex && r_ld_ex && (r_rd_ex != 5'd0) && !i_rst_pipe &&
                 (((r_rd_ex == w_rs1) && w_rs1_used) || ((r_rd_ex == w_rs2) && w_rs2_used));
  end

  // Register file write port from writeback; x0 writes dropped.
  always_ff @(posedge i_clk) begin
    if (i_wb_wen && (i_wb_rd != 5'd0)) begin
      r_rf[i_wb_rd] <= i_wb_wdata;
    end
  end

  // ID->EX register: reset > flush bubble > hold > load-use bubble > load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_ex    <= 1'b0;
      r_pc_ex       <= RESET_PC;
      r_rs1_data_ex <= '0;
      r_rs2_data_ex <= '0;
      r_rs1_ex      <= '0;
      r_rs2_ex      <= '0;
      r_rd_ex       <= '0;
      r_imm_ex      <= '0;
      r_opcode_ex   <= '0;
      r_funct3_ex   <= '0;
      r_funct7b5_ex <= 1'b0;
      r_wen_ex      <= 1'b0;
      r_ld_ex       <= 1'b0;
      r_st_ex       <= 1'b0;
      r_illegal_ex  <= 1'b0;
    end else if (i_rst_pipe) begin
      r_valid_ex   <= 1'b0;
      r_wen_ex     <= 1'b0;
      r_ld_ex      <= 1'b0;
      r_st_ex      <= 1'b0;
      r_illegal_ex <= 1'b0;
    end else if (!i_stall) begin
      // Data fields load unconditionally; a load-use bubble only kills control.
      r_pc_ex       <= i_pc_id;
      r_rs1_data_ex <= w_rs1_data;
      r_rs2_data_ex <= w_rs2_data;
      r_rs1_ex      <= w_rs1;
      r_rs2_ex      <= w_rs2;
      r_rd_ex       <= w_rd;
      r_imm_ex      <= w_imm;
      r_opcode_ex   <= w_opcode;
      r_funct3_ex   <= w_funct3;
      r_funct7b5_ex <= w_funct7b5;
      r_valid_ex    <= !w_stall_ld;
      r_wen_ex      <= w_wen && !w_illegal && !w_stall_ld;
      r_ld_ex       <= w_ld && !w_stall_ld;
      r_st_ex       <= w_st && !w_stall_ld;
      r_illegal_ex  <= w_illegal && !w_stall_ld;
    end
  end

  assign o_stall_ld    = w_stall_ld;
  assign o_valid_ex    = r_valid_ex;
  assign o_pc_ex       = r_pc_ex;
  assign o_rs1_data_ex = r_rs1_data_ex;
  assign o_rs2_data_ex = r_rs2_data_ex;
  assign o_rs1_ex      = r_rs1_ex;
  assign o_rs2_ex      = r_rs2_ex;
  assign o_rd_ex       = r_rd_ex;
  assign o_imm_ex      = r_imm_ex;
  assign o_opcode_ex   = r_opcode_ex;
  assign o_funct3_ex   = r_funct3_ex;
  assign o_funct7b5_ex = r_funct7b5_ex;
  assign o_wen_ex      = r_wen_ex;
  assign o_ld_ex       = r_ld_ex;
  assign o_st_ex       = r_st_ex;
  assign o_illegal_ex  = r_illegal_ex;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode of each immediate format,
// load-use stall, flush/hold priority, WB bypass and illegal opcode.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        stall;
  logic        rst_pipe;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        stall_ld;
  logic        valid_ex;
  logic [29:0] pc_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [4:0]  rs1_ex;
  logic [4:0]  rs2_ex;
  logic [4:0]  rd_ex;
  logic [31:0] imm_ex;
  logic [6:0]  opcode_ex;
  logic [2:0]  funct3_ex;
  logic        funct7b5_ex;
  logic        wen_ex;
  logic        ld_ex;
  logic        st_ex;
  logic        illegal_ex;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] InstAddX1   = 32'h000000B3;  // add  x1,x0,x0
  localparam logic [31:0] InstAddiM1  = 32'hFFF00093;  // addi x1,x0,-1
  localparam logic [31:0] InstSw      = 32'h00712423;  // sw   x7,8(x2)
  localparam logic [31:0] InstBeq     = 32'hFE208EE3;  // beq  x1,x2,-4
  localparam logic [31:0] InstJal     = 32'h001000EF;  // jal  x1,+0x800
  localparam logic [31:0] InstLui     = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] InstLw      = 32'h00012283;  // lw   x5,0(x2)
  localparam logic [31:0] InstAddUse  = 32'h00728333;  // add  x6,x5,x7
  localparam logic [31:0] InstAddX3   = 32'h00018233;  // add  x4,x3,x0

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BypassExp = 32'h1234_5678;
`else
  localparam logic [31:0] BypassExp = 32'h0000_0000;
`endif

  id_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_inst_id     (inst_id),
    .i_pc_id       (pc_id),
    .i_stall       (stall),
    .i_rst_pipe    (rst_pipe),
    .i_wb_wen      (wb_wen),
    .i_wb_rd       (wb_rd),
    .i_wb_wdata    (wb_wdata),
    .o_stall_ld    (stall_ld),
    .o_valid_ex    (valid_ex),
    .o_pc_ex       (pc_ex),
    .o_rs1_data_ex (rs1_data_ex),
    .o_rs2_data_ex (rs2_data_ex),
    .o_rs1_ex      (rs1_ex),
    .o_rs2_ex      (rs2_ex),
    .o_rd_ex       (rd_ex),
    .o_imm_ex      (imm_ex),
    .o_opcode_ex   (opcode_ex),
    .o_funct3_ex   (funct3_ex),
    .o_funct7b5_ex (funct7b5_ex),
    .o_wen_ex      (wen_ex),
    .o_ld_ex       (ld_ex),
    .o_st_ex       (st_ex),
    .o_illegal_ex  (illegal_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    inst_id  = InstAddX1;
    pc_id    = 30'h0;
    stall    = 1'b0;
    rst_pipe = 1'b0;
    wb_wen   = 1'b1;
    wb_rd    = 5'd0;
    wb_wdata = 32'hFFFF_FFFF;

    // Reset for two cycles while attempting a write to x0
    step();
    step();
    check("rst_valid", {31'd0, valid_ex}, 32'd0);
    check("rst_pc", {2'b0, pc_ex}, 32'd0);
    check("rst_imm", imm_ex, 32'd0);
    check("rst_rd", {27'd0, rd_ex}, 32'd0);
    check("rst_wen", {31'd0, wen_ex}, 32'd0);
    check("rst_ld", {31'd0, ld_ex}, 32'd0);
    check("rst_stall_ld", {31'd0, stall_ld}, 32'd0);

    // x0 reads zero after the ignored write
    rst = 1'b0;
    step();
    check("x0_rs1_data", rs1_data_ex, 32'd0);
    check("x0_rs2_data", rs2_data_ex, 32'd0);
    check("add_x1_valid", {31'd0, valid_ex}, 32'd1);
    check("add_x1_wen", {31'd0, wen_ex}, 32'd1);

    // Preload x7 and x2
    wb_rd = 5'd7; wb_wdata = 32'h0000_0777;
    step();
    wb_rd = 5'd2; wb_wdata = 32'h0000_0200;
    step();
    wb_wen = 1'b0;

    // I-type
    inst_id = InstAddiM1; pc_id = 30'h10;
    step();
    check("addi_imm", imm_ex, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, rd_ex}, 32'd1);
    check("addi_wen", {31'd0, wen_ex}, 32'd1);
    check("addi_pc", {2'b0, pc_ex}, 32'h10);
    check("addi_valid", {31'd0, valid_ex}, 32'd1);
    check("addi_opcode", {25'd0, opcode_ex}, 32'h13);

    // S-type
    inst_id = InstSw; pc_id = 30'h11;
    step();
    check("sw_imm", imm_ex, 32'h8);
    check("sw_st", {31'd0, st_ex}, 32'd1);
    check("sw_wen", {31'd0, wen_ex}, 32'd0);
    check("sw_rs1_data", rs1_data_ex, 32'h200);
    check("sw_rs2_data", rs2_data_ex, 32'h777);
    check("sw_funct3", {29'd0, funct3_ex}, 32'd2);

    // B-type
    inst_id = InstBeq; pc_id = 30'h12;
    step();
    check("beq_imm", imm_ex, 32'hFFFF_FFFC);
    check("beq_wen", {31'd0, wen_ex}, 32'd0);

    // J-type
    inst_id = InstJal; pc_id = 30'h13;
    step();
    check("jal_imm", imm_ex, 32'h800);
    check("jal_wen", {31'd0, wen_ex}, 32'd1);

    // U-type
    inst_id = InstLui; pc_id = 30'h14;
    step();
    check("lui_imm", imm_ex, 32'h1234_5000);
    check("lui_wen", {31'd0, wen_ex}, 32'd1);

    // Illegal opcode
    inst_id = 32'h0000_0000; pc_id = 30'h15;
    step();
    check("ill_illegal", {31'd0, illegal_ex}, 32'd1);
    check("ill_valid", {31'd0, valid_ex}, 32'd1);
    check("ill_wen", {31'd0, wen_ex}, 32'd0);

    // Load-use: lw x5 then add x6,x5,x7
    inst_id = InstLw; pc_id = 30'h20;
    step();
    check("lw_ld", {31'd0, ld_ex}, 32'd1);
    inst_id = InstAddUse; pc_id = 30'h21;
    #1;
    check("lu_stall_on", {31'd0, stall_ld}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, valid_ex}, 32'd0);
    check("lu_bubble_wen", {31'd0, wen_ex}, 32'd0);
    check("lu_stall_off", {31'd0, stall_ld}, 32'd0);
    step();
    check("lu_add_valid", {31'd0, valid_ex}, 32'd1);
    check("lu_add_rs1", {27'd0, rs1_ex}, 32'd5);
    check("lu_add_rs2", {27'd0, rs2_ex}, 32'd7);
    check("lu_add_pc", {2'b0, pc_ex}, 32'h21);

    // lw then lui x5: rs1 unused, no hazard
    inst_id = InstLw; pc_id = 30'h22;
    step();
    inst_id = InstLui; pc_id = 30'h23;
    #1;
    check("lw_lui_nostall", {31'd0, stall_ld}, 32'd0);
    step();
    check("lw_lui_valid", {31'd0, valid_ex}, 32'd1);

    // stall with pending load-use: hold wins, stall_ld stays high
    inst_id = InstLw; pc_id = 30'h24;
    step();
    inst_id = InstAddUse; pc_id = 30'h25; stall = 1'b1;
    step();
    check("hold_ld", {31'd0, ld_ex}, 32'd1);
    check("hold_pc", {2'b0, pc_ex}, 32'h24);
    check("hold_stall_ld", {31'd0, stall_ld}, 32'd1);

    // flush with stall and pending load-use: flush wins, stall_ld gated
    rst_pipe = 1'b1;
    #1;
    check("flush_gate", {31'd0, stall_ld}, 32'd0);
    step();
    rst_pipe = 1'b0; stall = 1'b0;
    check("flush_valid", {31'd0, valid_ex}, 32'd0);
    check("flush_wen", {31'd0, wen_ex}, 32'd0);
    check("flush_stall_ld", {31'd0, stall_ld}, 32'd0);

    // reset mid-operation discards the pending load
    inst_id = InstLw; pc_id = 30'h26;
    step();
    inst_id = InstAddUse; pc_id = 30'h27; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", {31'd0, valid_ex}, 32'd0);
    check("midrst_pc", {2'b0, pc_ex}, 32'd0);
    check("midrst_stall_ld", {31'd0, stall_ld}, 32'd0);

    // WB->ID bypass: clear x3, then write 0x12345678 while decoding x3
    wb_wen = 1'b1; wb_rd = 5'd3; wb_wdata = 32'd0; inst_id = InstAddX1;
    step();
    wb_wdata = 32'h1234_5678; inst_id = InstAddX3; pc_id = 30'h30;
    step();
    check("bypass_rs1_data", rs1_data_ex, BypassExp);
    wb_wen = 1'b0;
    step();
    check("after_wb_rs1_data", rs1_data_ex, 32'h1234_5678);
    check("after_wb_rd", {27'd0, rd_ex}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
